// File: rtl/cpu_pkg.sv
// Shared opcode/state types and instruction-field helpers for the
// multicycle core cpu_core_mc and its ALU.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_LDI = 4'd8,
    OP_LD  = 4'd9,
    OP_ST  = 4'd10,
    OP_JMP = 4'd11,
    OP_JZ  = 4'd12,
    OP_JC  = 4'd13,
    OP_MOV = 4'd14,
    OP_HLT = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  localparam int FLD_IMM = 0;
  localparam int FLD_RS  = 1;
  localparam int FLD_RD  = 2;
  localparam int FLD_OP  = 3;

  // Instruction layout, msb first: op(4) | rd(ra) | rs(ra) | imm(dw).
  function automatic int fld_lsb(
    input int fld,
    input int ra,
    input int dw
  );
    case (fld)
      FLD_IMM: return 0;
      FLD_RS:  return dw;
      FLD_RD:  return dw + ra;
      default: return dw + 2 * ra;
    endcase
  endfunction

  function automatic logic op_writes_rd(input op_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                      OP_XOR, OP_SHL, OP_SHR, OP_LDI,
                      OP_LD, OP_MOV};
  endfunction

  function automatic logic op_sets_flags(input op_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                      OP_XOR, OP_SHL, OP_SHR};
  endfunction

endpackage

// File: rtl/cpu_core_mc_alu.sv
// cpu_alu_p: combinational ALU for the multicycle core.
// Non-ALU opcodes pass b through (used for LDI), MOV passes a.
module cpu_alu_p
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] res,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] ext;

  // Select the result and its carry/borrow for the opcode
  always_comb begin
    ext   = '0;
    res   = b;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        res   = ext[DATA_W-1:0];
        carry = ext[DATA_W];
      end
      OP_SUB: begin
        ext   = {1'b0, a} - {1'b0, b};
        res   = ext[DATA_W-1:0];
        carry = ext[DATA_W];
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin
        res   = {a[DATA_W-2:0], 1'b0};
        carry = a[DATA_W-1];
      end
      OP_SHR: begin
        res   = {1'b0, a[DATA_W-1:1]};
        carry = a[0];
      end
      OP_MOV: res = a;
      default: res = b;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multicycle core with req/ack instruction and data ports.
// Optional retire counter port enabled by CPU_CORE_RETIRE_CNT_EN.
module cpu_core_mc
  import cpu_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int REG_CNT = 16,
  parameter  int ADDR_W  = 8,
  localparam int RA      = $clog2(REG_CNT),
  localparam int INST_W  = 4 + 2 * RA + DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg
`ifdef CPU_CORE_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  localparam int RS_LSB = fld_lsb(FLD_RS, RA, DATA_W);
  localparam int RD_LSB = fld_lsb(FLD_RD, RA, DATA_W);
  localparam int OP_LSB = fld_lsb(FLD_OP, RA, DATA_W);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] ir_q;
  logic [DATA_W-1:0] rf [REG_CNT];
  logic              z_q, c_q;
  logic [DATA_W-1:0] res_q;
  logic              zres_q, cres_q;
  logic              take_q;

  op_e               op;
  logic [RA-1:0]     rd, rs, rs2;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] imm_a;
  logic [DATA_W-1:0] a_val, b_val;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_z;
  logic              take;
  logic              i_done, d_done;

  assign op    = op_e'(ir_q[OP_LSB +: 4]);
  assign rd    = ir_q[RD_LSB +: RA];
  assign rs    = ir_q[RS_LSB +: RA];
  assign imm   = ir_q[DATA_W-1:0];
  assign rs2   = imm[RA-1:0];
  assign imm_a = ADDR_W'(imm);

  assign a_val = rf[rs];
  assign b_val = (op == OP_LDI) ? imm : rf[rs2];

  // An ack only counts while our own request is up.
  assign i_done = imem_req & imem_ack;
  assign d_done = dmem_req & dmem_ack;

  assign imem_addr = pc_q;
  assign pc_dbg    = pc_q;

  cpu_alu_p #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a     (a_val),
    .b     (b_val),
    .op    (op),
    .res   (alu_res),
    .carry (alu_c),
    .zero  (alu_z)
  );

  // Branch resolution from the committed flags
  always_comb begin
    take = 1'b0;
    unique case (1'b1)
      op == OP_JMP: take = 1'b1;
      op == OP_JZ:  take = z_q;
      op == OP_JC:  take = c_q;
      default:      take = 1'b0;
    endcase
  end

  // Next-state logic of the instruction sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: if (i_done) state_d = ST_EXEC;
      ST_EXEC: begin
        if (op == OP_LD || op == OP_ST)
          state_d = ST_MEM;
        else if (op == OP_HLT)
          state_d = ST_HALT;
        else
          state_d = ST_WB;
      end
      ST_MEM:  if (d_done) state_d = ST_WB;
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Registered handshake outputs, raised on entry to their state
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      halted     <= 1'b0;
    end else begin
      imem_req <= (state_d == ST_FETCH);
      dmem_req <= (state_d == ST_MEM);
      halted   <= (state_d == ST_HALT);
      if (state_q == ST_EXEC && state_d == ST_MEM) begin
        dmem_we    <= (op == OP_ST);
        dmem_addr  <= imm_a;
        dmem_wdata <= rf[rd];
      end else if (d_done) begin
        dmem_we <= 1'b0;
      end
    end
  end

  // Datapath: IR latch, execute results, load data, writeback
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q   <= '0;
      ir_q   <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      res_q  <= '0;
      zres_q <= 1'b0;
      cres_q <= 1'b0;
      take_q <= 1'b0;
      for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
    end else begin
      case (state_q)
        ST_FETCH: if (i_done) ir_q <= imem_rdata;
        ST_EXEC: begin
          res_q  <= alu_res;
          zres_q <= alu_z;
          cres_q <= alu_c;
          take_q <= take;
        end
        ST_MEM: if (d_done && !dmem_we) res_q <= dmem_rdata;
        ST_WB: begin
          if (op_writes_rd(op)) rf[rd] <= res_q;
          if (op_sets_flags(op)) begin
            z_q <= zres_q;
            c_q <= cres_q;
          end
          pc_q <= take_q ? imm_a : pc_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_CORE_RETIRE_CNT_EN
  // One count per writeback, i.e. per retired instruction
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                retire_cnt <= '0;
    else if (state_q == ST_WB) retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule

// File: doc/cpu_core_mc.md
Name: cpu_core_mc

Overview:
- Parametrised multicycle successor to the current single-cycle CPU.
- Keeps the same ALU/register-file/data-memory style.
- Moves instruction and data memory outside the core, behind req/ack handshakes, so slow or shared memories can stall it.
- Sits between the system top and external IM/DM wrappers. Adds a HALT state, carry/zero flags, and a debug view of the PC.

Parameters:
- DATA_W, 8, datapath, register and data-memory word width (>=4).
- REG_CNT, 16, number of general registers (power of 2, >=2); RA = log2(REG_CNT).
- ADDR_W, 8, PC and data-address width. PC wraps modulo 2^ADDR_W.
- INST_W, 4+2*RA+DATA_W, instruction width (derived; do not override). Fields: op[INST_W-1 -: 4], rd[next RA], rs[next RA], imm[DATA_W-1:0]. rs2 = imm[RA-1:0].

Ports:
- CLK, in, 1, core clock; all state changes on its rising edge.
- RESET, in, 1, asynchronous, active-low reset.
- imem_req, out, 1, instruction fetch request.
- imem_addr, out, ADDR_W, fetch address (= PC).
- imem_ack, in, 1, fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata, in, INST_W, fetched instruction.
- dmem_req, out, 1, data access request.
- dmem_we, out, 1, 1 = store, 0 = load.
- dmem_addr, out, ADDR_W, data address (zero-extended or truncated imm).
- dmem_wdata, out, DATA_W, store data.
- dmem_ack, in, 1, access complete; dmem_rdata is valid in the same cycle for loads.
- dmem_rdata, in, DATA_W, load data.
- halted, out, 1, core in HALT state.
- pc_dbg, out, ADDR_W, current PC.

Behaviour:
- Reset (RESET=0, asynchronous):
  - PC=0, all registers=0, Z=C=0, IR=0, state=FETCH.
  - imem_req, dmem_req, dmem_we, halted all 0; dmem_addr and dmem_wdata 0.
  - Reset mid-handshake drops the request immediately. A late ack arriving after reset is ignored.
- Handshakes:
  - A request rises in the cycle after entering its state.
  - Address, data and we are held stable until the ack cycle.
  - The request falls in the cycle after the ack.
  - At most one outstanding access. An ack while the request is low is ignored.
- FSM: FETCH -> EXEC -> (MEM) -> WB -> FETCH; HALT is terminal.
  - FETCH: drive imem_req with imem_addr=PC. On imem_ack, latch IR <= imem_rdata and go to EXEC.
  - EXEC: read rs, rs2, rd; compute; resolve branches. LD/ST go to MEM; HLT goes to HALT; all others go to WB.
  - MEM: drive dmem_req. On dmem_ack, latch load data and go to WB.
  - WB: write rd if the opcode writes. PC <= branch-taken ? imm[ADDR_W-1:0] : PC+1. Go to FETCH.
  - HALT: all requests low, halted=1. Stays until reset.
- Opcodes:
  - 0 NOP.
  - 1 ADD rd=rs+rs2; C = carry-out bit DATA_W.
  - 2 SUB rd=rs-rs2; C = borrow (rs<rs2 unsigned).
  - 3 AND. 4 OR. 5 XOR (these three leave C=0).
  - 6 SHL rd=rs<<1; C = old msb.
  - 7 SHR rd=rs>>1, logical; C = old lsb.
  - 8 LDI rd=imm.
  - 9 LD rd=DM[imm].
  - 10 ST DM[imm]=rd.
  - 11 JMP.
  - 12 JZ, taken if Z=1.
  - 13 JC, taken if C=1.
  - 14 MOV rd=rs.
  - 15 HLT.
- Flags: Z = (result==0). Z and C are updated only by opcodes 1-7, in WB.
- Minimum latency per instruction: 3 cycles plus handshake waits; 4 cycles plus waits for LD/ST.
- Writing rd where rd==rs is legal; the operand is read before the write.
- PC+1 at 2^ADDR_W-1 wraps to 0.

Optional Feature:
- Macro CPU_CORE_RETIRE_CNT_EN.
- When defined: adds output port retire_cnt, 32 bits.
  - Reset to 0.
  - Increments by 1 in each WB cycle, i.e. once per retired instruction. HLT does not count.
  - Wraps at 2^32.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams/enum (OP_NOP..OP_HLT);
  - FSM state enum (ST_FETCH, ST_EXEC, ST_MEM, ST_WB, ST_HALT);
  - the field-offset function for INST_W/RA.
- Sub-module cpu_alu_p (parametrised DATA_W) is combinational. Inputs: a, b, op. Outputs: res, carry, zero.
- Register file and FSM are inline in cpu_core_mc.

Test Plan:
- Reset, then a memory model with a 0-wait ack. Program: LDI R1,5; LDI R2,3; ADD R3,R1,R2; HLT.
  - Expect R3=8, Z=0, C=0, halted=1 after 4 instructions, pc_dbg=3.
- ADD overflow at DATA_W=8: 0xFF+0x01.
  - Expect R=0x00, C=1, Z=1. A following JZ 0x20 makes the next imem_addr 0x20.
- Load/store with dmem_ack delayed 3 cycles: ST R1 to [0x10] (R1=0xA5), then LD R4,[0x10].
  - Expect dmem_req held high 4 cycles with addr 0x10.
  - Expect dmem_we=1 then 0. R4=0xA5.
- RESET pulsed low while imem_req=1 and ack is pending.
  - Expect imem_req=0 immediately, PC=0. A late ack is ignored; fetch restarts at 0.
- Parameter sweep DATA_W=16, REG_CNT=4: SUB 0x0000-0x0001.
  - Expect 0xFFFF, C=1. PC wrap from 0xFF to 0x00 at ADDR_W=8.
- With CPU_CORE_RETIRE_CNT_EN: a 10-instruction program ending in HLT.
  - Expect retire_cnt=9, stable after halt.
